// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed dual-bank 7-segment scan controller:
// segment decode table, blank pattern and scan FSM encoding.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_SHOW  = 2'd0,
    ST_BLANK = 2'd1,
    ST_FRAME = 2'd2
  } scan_state_e;

  localparam int unsigned NUM_POS   = 4;
  localparam logic [6:0]  SEG_BLANK = 7'b0000000;

  // Segment order a..g maps to bits 6..0; entry [9] is listed first.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder; non-decimal codes A..F render blank.
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_TABLE[bcd_i];
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Lockstep scanner for a theoretical and a real 4-digit display bank, with
// frame-synchronous shadow update handshake and fully registered outputs.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DWELL = 10,
  parameter int unsigned BLANK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_dis,
  input  logic [15:0] the_bcd,
  input  logic [15:0] real_bcd,
  input  logic [3:0]  dis_the4,
  input  logic [3:0]  dis_real4,
  input  logic [13:0] dis_all,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [7:0]  dis_dig,
  output logic [13:0] dis_num,
  output logic [1:0]  dis_dp,
  output logic        frame_done
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LAST = (BLANK == 0) ? 8'd0 : 8'(BLANK - 1);
  localparam bit         HAS_BLANK  = (BLANK != 0);

  scan_state_e state_q, state_d;
  logic [1:0]  pos_q, pos_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] the_q, the_d, real_q, real_d;
  logic [3:0]  dpt_q, dpt_d, dpr_q, dpr_d;

  logic [7:0]  dig_q, dig_d;
  logic [13:0] num_q, num_d;
  logic [1:0]  dp_q, dp_d;
  logic        ack_q, ack_d;
  logic        fd_q, fd_d;

  logic [6:0]  seg_the, seg_real;
  logic [3:0]  pos_oh;

  seg7_dec u_dec_the (
    .bcd_i (the_q[{pos_q, 2'b00} +: 4]),
    .seg_o (seg_the)
  );

  seg7_dec u_dec_real (
    .bcd_i (real_q[{pos_q, 2'b00} +: 4]),
    .seg_o (seg_real)
  );

  assign pos_oh = 4'b0001 << pos_q;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q + 8'd1;
    the_d   = the_q;
    real_d  = real_q;
    dpt_d   = dpt_q;
    dpr_d   = dpr_q;
    dig_d   = '0;
    num_d   = '0;
    dp_d    = '0;
    ack_d   = 1'b0;
    fd_d    = 1'b0;

    unique case (state_q)
      ST_SHOW: begin
        dig_d = {pos_oh, pos_oh};
        if (ctrl_dis) begin
          num_d = {seg_the, seg_real};
          dp_d  = {dpt_q[pos_q], dpr_q[pos_q]};
        end else begin
          num_d = dis_all;
        end
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (HAS_BLANK) begin
            state_d = ST_BLANK;
          end else if (pos_q == 2'd0) begin
            state_d = ST_FRAME;
          end else begin
            pos_d = pos_q - 2'd1;
          end
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d = '0;
          if (pos_q == 2'd0) begin
            state_d = ST_FRAME;
          end else begin
            state_d = ST_SHOW;
            pos_d   = pos_q - 2'd1;
          end
        end
      end
      ST_FRAME: begin
        fd_d    = 1'b1;
        state_d = ST_SHOW;
        pos_d   = 2'(NUM_POS - 1);
        cnt_d   = '0;
        // Only point where the shadow copy may change, so a frame never tears.
        if (upd_req) begin
          ack_d  = 1'b1;
          the_d  = the_bcd;
          real_d = real_bcd;
          dpt_d  = dis_the4;
          dpr_d  = dis_real4;
        end
      end
      default: begin
        state_d = ST_SHOW;
        pos_d   = 2'(NUM_POS - 1);
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SHOW;
      pos_q   <= 2'(NUM_POS - 1);
      cnt_q   <= '0;
      // NOTE: the shadow registers are reset too, so the display starts blank rather than random.
      the_q   <= 16'hFFFF;
      real_q  <= 16'hFFFF;
      dpt_q   <= '0;
      dpr_q   <= '0;
      dig_q   <= '0;
      num_q   <= '0;
      dp_q    <= '0;
      ack_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      the_q   <= the_d;
      real_q  <= real_d;
      dpt_q   <= dpt_d;
      dpr_q   <= dpr_d;
      dig_q   <= dig_d;
      num_q   <= num_d;
      dp_q    <= dp_d;
      ack_q   <= ack_d;
      fd_q    <= fd_d;
    end
  end

  assign dis_dig    = dig_q;
  assign dis_num    = num_q;
  assign dis_dp     = dp_q;
  assign upd_ack    = ack_q;
  assign frame_done = fd_q;

endmodule
